// File: rtl/i2c_line_conditioner.sv
// I2C pad-side line conditioner: synchroniser, glitch filter, START/STOP detect, bus busy.
// Ports:
//   clk, rst (async active-high)
//   scl_pad_i, sda_pad_i       raw pad inputs (asynchronous)
//   scl_f_o, sda_f_o           filtered lines
//   start_det_o, stop_det_o    one-cycle condition pulses
//   bus_busy_o                 high between START and STOP/timeout
//   glitch_clr_i, glitch_cnt_o rejected-glitch counter (present only with I2C_GLITCH_CNT_EN)
// Optional build macro: I2C_GLITCH_CNT_EN
module i2c_line_conditioner #(
    parameter int FILTER_LEN      = 4,
    parameter int BUS_FREE_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_pad_i,
    input  logic       sda_pad_i,
    output logic       scl_f_o,
    output logic       sda_f_o,
    output logic       start_det_o,
    output logic       stop_det_o,
    output logic       bus_busy_o,
    input  logic       glitch_clr_i,
    output logic [7:0] glitch_cnt_o
);

    localparam int              FW       = $clog2(BUS_FREE_CYCLES + 1);
    localparam logic [3:0]      FL_M1    = 4'(FILTER_LEN - 1);
    localparam logic [FW-1:0]   FREE_MAX = FW'(BUS_FREE_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    logic          r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic          r_scl_f, r_sda_f;
    logic [3:0]    r_scl_cnt, r_sda_cnt;
    logic          r_p_scl, r_p_sda;
    logic          r_start, r_stop;
    logic [FW-1:0] r_free_cnt;
    logic [FW-1:0] w_free_nxt;
    logic          w_start, w_stop, w_both_hi;
    state_t        r_state, w_state_nxt;

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= scl_pad_i;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda_pad_i;
            r_sda_s2 <= r_sda_s1;
        end
    end

    // A new level is accepted only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_f   <= 1'b1;
            r_scl_cnt <= 4'd0;
        end else if (r_scl_s2 != r_scl_f) begin
            if (r_scl_cnt == FL_M1) begin
                r_scl_f   <= r_scl_s2;
                r_scl_cnt <= 4'd0;
            end else begin
                r_scl_cnt <= r_scl_cnt + 4'd1;
            end
        end else begin
            r_scl_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sda_f   <= 1'b1;
            r_sda_cnt <= 4'd0;
        end else if (r_sda_s2 != r_sda_f) begin
            if (r_sda_cnt == FL_M1) begin
                r_sda_f   <= r_sda_s2;
                r_sda_cnt <= 4'd0;
            end else begin
                r_sda_cnt <= r_sda_cnt + 4'd1;
            end
        end else begin
            r_sda_cnt <= 4'd0;
        end
    end

    // SCL must be high before and after the SDA edge, so a simultaneous
    // SCL change never qualifies.
    assign w_start   = r_p_sda & ~r_sda_f & r_p_scl & r_scl_f;
    assign w_stop    = ~r_p_sda & r_sda_f & r_p_scl & r_scl_f;
    assign w_both_hi = r_scl_f & r_sda_f;

    always_comb begin
        w_free_nxt = '0;
        if (w_both_hi) begin
            if (r_free_cnt == FREE_MAX) begin
                w_free_nxt = FREE_MAX;
            end else begin
                w_free_nxt = r_free_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_scl    <= 1'b1;
            r_p_sda    <= 1'b1;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_free_cnt <= '0;
        end else begin
            r_p_scl    <= r_scl_f;
            r_p_sda    <= r_sda_f;
            r_start    <= w_start;
            r_stop     <= w_stop;
            r_free_cnt <= w_free_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Timeout fires on the edge where the free counter reaches its limit,
    // so busy falls together with that update.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_start) begin
                    w_state_nxt = ST_BUSY;
                end else if (w_stop || (w_free_nxt == FREE_MAX)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign scl_f_o     = r_scl_f;
    assign sda_f_o     = r_sda_f;
    assign start_det_o = r_start;
    assign stop_det_o  = r_stop;
    assign bus_busy_o  = (r_state == ST_BUSY);

`ifdef I2C_GLITCH_CNT_EN
    logic       w_rej_scl, w_rej_sda;
    logic [8:0] w_sum;
    logic [7:0] r_glitch_cnt;

    // A run of differing samples that ends before acceptance is one glitch.
    assign w_rej_scl = (r_scl_s2 == r_scl_f) && (r_scl_cnt != 4'd0);
    assign w_rej_sda = (r_sda_s2 == r_sda_f) && (r_sda_cnt != 4'd0);
    assign w_sum     = {1'b0, r_glitch_cnt} + 9'(w_rej_scl) + 9'(w_rej_sda);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_glitch_cnt <= 8'd0;
        end else if (glitch_clr_i) begin
            r_glitch_cnt <= 8'd0;
        end else if (w_sum[8]) begin
            r_glitch_cnt <= 8'd255;
        end else begin
            r_glitch_cnt <= w_sum[7:0];
        end
    end

    assign glitch_cnt_o = r_glitch_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr = glitch_clr_i;
    assign glitch_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Directed self-checking bench for i2c_line_conditioner.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_i2c_line_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_pad_i, sda_pad_i;
    logic       scl_f_o, sda_f_o;
    logic       start_det_o, stop_det_o, bus_busy_o;
    logic       glitch_clr_i;
    logic [7:0] glitch_cnt_o;

    int n_pass  = 0;
    int n_total = 0;
    int n_start = 0;
    int n_stop  = 0;
    int n_idle  = 0;

`ifdef I2C_GLITCH_CNT_EN
    localparam int G1   = 1;
    localparam int G254 = 254;
    localparam int G255 = 255;
`else
    localparam int G1   = 0;
    localparam int G254 = 0;
    localparam int G255 = 0;
`endif

    i2c_line_conditioner #(
        .FILTER_LEN(4),
        .BUS_FREE_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .scl_pad_i(scl_pad_i),
        .sda_pad_i(sda_pad_i),
        .scl_f_o(scl_f_o),
        .sda_f_o(sda_f_o),
        .start_det_o(start_det_o),
        .stop_det_o(stop_det_o),
        .bus_busy_o(bus_busy_o),
        .glitch_clr_i(glitch_clr_i),
        .glitch_cnt_o(glitch_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (start_det_o) n_start++;
        if (stop_det_o) n_stop++;
        if (!bus_busy_o) n_idle++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_counts();
        n_start = 0;
        n_stop  = 0;
        n_idle  = 0;
    endtask

    task automatic dual_glitch();
        scl_pad_i = 1'b0;
        sda_pad_i = 1'b0;
        ticks(2);
        scl_pad_i = 1'b1;
        sda_pad_i = 1'b1;
        ticks(2);
    endtask

    logic sda_h [1:10];
    logic st_h  [1:10];
    logic sp_h  [1:10];
    logic bz_h  [1:10];
    int   t_rise;
    int   t_drop;
    bit   sda_low_seen;

    initial begin
        rst          = 1'b1;
        scl_pad_i    = 1'b1;
        sda_pad_i    = 1'b1;
        glitch_clr_i = 1'b0;

        // T1: reset and idle
        ticks(3);
        check("rst_scl_f", int'(scl_f_o), 1);
        check("rst_sda_f", int'(sda_f_o), 1);
        check("rst_busy", int'(bus_busy_o), 0);
        check("rst_gcnt", int'(glitch_cnt_o), 0);
        rst = 1'b0;
        clr_counts();
        ticks(100);
        check("t1_start_cnt", n_start, 0);
        check("t1_stop_cnt", n_stop, 0);
        check("t1_idle_cnt", n_idle, 100);
        check("t1_scl_f", int'(scl_f_o), 1);
        check("t1_sda_f", int'(sda_f_o), 1);

        // T2: 3-clock SDA glitch is rejected
        sda_low_seen = 1'b0;
        sda_pad_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!sda_f_o) sda_low_seen = 1'b1;
        end
        sda_pad_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!sda_f_o) sda_low_seen = 1'b1;
        end
        check("t2_sda_f_low", int'(sda_low_seen), 0);
        check("t2_gcnt", int'(glitch_cnt_o), G1);

        // T3: clean START timing
        clr_counts();
        sda_pad_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            sda_h[i] = sda_f_o;
            st_h[i]  = start_det_o;
            bz_h[i]  = bus_busy_o;
        end
        check("t3_sda_f_k5", int'(sda_h[5]), 1);
        check("t3_sda_f_k6", int'(sda_h[6]), 0);
        check("t3_start_k6", int'(st_h[6]), 0);
        check("t3_start_k7", int'(st_h[7]), 1);
        check("t3_start_k8", int'(st_h[8]), 0);
        check("t3_busy_k6", int'(bz_h[6]), 0);
        check("t3_busy_k7", int'(bz_h[7]), 1);
        check("t3_start_cnt", n_start, 1);

        // T4: STOP
        clr_counts();
        sda_pad_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            sp_h[i] = stop_det_o;
            bz_h[i] = bus_busy_o;
        end
        check("t4_stop_k6", int'(sp_h[6]), 0);
        check("t4_stop_k7", int'(sp_h[7]), 1);
        check("t4_stop_k8", int'(sp_h[8]), 0);
        check("t4_busy_k6", int'(bz_h[6]), 1);
        check("t4_busy_k7", int'(bz_h[7]), 0);
        check("t4_stop_cnt", n_stop, 1);

        // T4b: repeated START while busy
        sda_pad_i = 1'b0;
        ticks(10);
        check("t4_rs_busy0", int'(bus_busy_o), 1);
        clr_counts();
        scl_pad_i = 1'b0;
        ticks(10);
        sda_pad_i = 1'b1;
        ticks(10);
        scl_pad_i = 1'b1;
        ticks(10);
        sda_pad_i = 1'b0;
        ticks(10);
        check("t4_rs_start_cnt", n_start, 1);
        check("t4_rs_stop_cnt", n_stop, 0);
        check("t4_rs_idle_cnt", n_idle, 0);

        // T5: bus-free timeout
        clr_counts();
        scl_pad_i = 1'b0;
        ticks(10);
        sda_pad_i = 1'b1;
        ticks(10);
        scl_pad_i = 1'b1;
        t_rise = -1;
        t_drop = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (t_rise < 0 && scl_f_o) t_rise = i;
            if (t_drop < 0 && !bus_busy_o) t_drop = i;
        end
        check("t5_scl_rise", t_rise, 6);
        check("t5_timeout", t_drop - t_rise, 64);
        check("t5_stop_cnt", n_stop, 0);
        check("t5_start_cnt", n_start, 0);

        // T6: glitch counter saturation and clear priority
        glitch_clr_i = 1'b1;
        tick();
        glitch_clr_i = 1'b0;
        check("t6_clr", int'(glitch_cnt_o), 0);
        clr_counts();
        for (int i = 0; i < 127; i++) dual_glitch();
        tick();
        check("t6_cnt254", int'(glitch_cnt_o), G254);
        dual_glitch();
        tick();
        check("t6_cnt255", int'(glitch_cnt_o), G255);
        for (int i = 0; i < 22; i++) dual_glitch();
        tick();
        check("t6_sat", int'(glitch_cnt_o), G255);
        check("t6_scl_f", int'(scl_f_o), 1);
        check("t6_no_start", n_start, 0);
        dual_glitch();
        glitch_clr_i = 1'b1;
        tick();
        glitch_clr_i = 1'b0;
        check("t6_clr_win", int'(glitch_cnt_o), 0);
        ticks(3);
        check("t6_clr_hold", int'(glitch_cnt_o), 0);

        // T6b: reset while busy
        sda_pad_i = 1'b0;
        ticks(10);
        check("t6_busy_pre", int'(bus_busy_o), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", int'(bus_busy_o), 0);
        check("t6_rst_sda_f", int'(sda_f_o), 1);
        check("t6_rst_start", int'(start_det_o), 0);
        sda_pad_i = 1'b1;
        ticks(2);
        rst = 1'b0;
        clr_counts();
        ticks(20);
        check("t6_post_start", n_start, 0);
        check("t6_post_stop", n_stop, 0);
        check("t6_post_idle", n_idle, 20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
